// File: rtl/dna_reader_pkg.sv
// dna_reader_pkg: FSM state encoding and default sizes shared by dna_reader.
// No ports; import with dna_reader_pkg::*.
package dna_reader_pkg;

  localparam int DNA_BITS_DEF = 96;
  localparam int WORD_W_DEF   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SEND,
    ST_DONE
  } dna_state_e;

endpackage

// File: rtl/dna_reader.sv
// dna_reader: reads the device DNA serially, then streams it as words.
// Ports: iClock/iReset_n, iStart, oBusy, DNA port pins (oDnaRead,
//   oDnaShift, oDnaDin, iDnaDout), oDna/oDnaValid capture,
//   oWord/oWordValid/iWordReady stream.
// Option: DNA_READER_AUTOSTART_EN starts one read after each reset.
module dna_reader
  import dna_reader_pkg::*;
#(
  parameter int DNA_BITS = DNA_BITS_DEF,
  parameter int WORD_W   = WORD_W_DEF
) (
  input  logic                iClock,
  input  logic                iReset_n,
  input  logic                iStart,
  output logic                oBusy,
  output logic                oDnaRead,
  output logic                oDnaShift,
  output logic                oDnaDin,
  input  logic                iDnaDout,
  output logic [DNA_BITS-1:0] oDna,
  output logic                oDnaValid,
  output logic [WORD_W-1:0]   oWord,
  output logic                oWordValid,
  input  logic                iWordReady
);

  localparam int NWORDS = DNA_BITS / WORD_W;
  localparam int CNT_W  = $clog2(DNA_BITS);
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  dna_state_e          r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic [DNA_BITS-1:0] r_dna, w_dna;
  logic                r_dna_valid, w_dna_valid;
  logic                r_read, w_read;
  logic                r_shift, w_shift;
  logic                r_busy, w_busy;
  logic [WORD_W-1:0]   r_word, w_word;
  logic                r_word_valid, w_word_valid;
  logic [DNA_BITS-1:0] w_cap;
  logic                w_start;

`ifdef DNA_READER_AUTOSTART_EN
  // Low only until the first edge after reset release.
  logic r_auto_done;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) r_auto_done <= 1'b0;
    else           r_auto_done <= 1'b1;
  end

  assign w_start = iStart | ~r_auto_done;
`else
  assign w_start = iStart;
`endif

  // First bit out lands in bit 0 after DNA_BITS shifts.
  assign w_cap = {iDnaDout, r_dna[DNA_BITS-1:1]};

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_idx        = r_idx;
    w_dna        = r_dna;
    w_dna_valid  = r_dna_valid;
    w_read       = 1'b0;
    w_shift      = 1'b0;
    w_word       = r_word;
    w_word_valid = r_word_valid;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          w_state     = ST_LOAD;
          w_dna       = '0;
          w_dna_valid = 1'b0;
          w_read      = 1'b1;
          w_cnt       = '0;
          w_idx       = '0;
        end
      end
      ST_LOAD: begin
        w_state = ST_SHIFT;
        w_shift = 1'b1;
        w_cnt   = '0;
      end
      ST_SHIFT: begin
        w_dna = w_cap;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state      = ST_SEND;
          w_dna_valid  = 1'b1;
          w_idx        = '0;
          w_word       = w_cap[WORD_W-1:0];
          w_word_valid = 1'b1;
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_SEND: begin
        if (iWordReady) begin
          if (r_idx == IDX_LAST) begin
            w_state      = ST_DONE;
            w_word_valid = 1'b0;
          end else begin
            w_idx  = r_idx + 1'b1;
            w_word = r_dna[int'(w_idx)*WORD_W +: WORD_W];
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state == ST_LOAD) ||
             (w_state == ST_SHIFT) ||
             (w_state == ST_SEND);
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_dna        <= '0;
      r_dna_valid  <= 1'b0;
      r_read       <= 1'b0;
      r_shift      <= 1'b0;
      r_busy       <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_idx        <= w_idx;
      r_dna        <= w_dna;
      r_dna_valid  <= w_dna_valid;
      r_read       <= w_read;
      r_shift      <= w_shift;
      r_busy       <= w_busy;
      r_word       <= w_word;
      r_word_valid <= w_word_valid;
    end
  end

  assign oBusy      = r_busy;
  assign oDnaRead   = r_read;
  assign oDnaShift  = r_shift;
  assign oDnaDin    = 1'b0;
  assign oDna       = r_dna;
  assign oDnaValid  = r_dna_valid;
  assign oWord      = r_word;
  assign oWordValid = r_word_valid;

endmodule
